// File: rtl/id_control_sequencer_pkg.sv
// rtl/id_control_sequencer_pkg.sv - shared opcodes, immediate-select encodings and sequencer states
package id_control_sequencer_pkg;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_U    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_HOLD = 1'b1
  } seq_state_e;

  // DIV/DIVU/REM/REMU: M-extension R-type with funct3[2] set; MUL* keep funct3[2] clear.
  function automatic logic is_divide(input logic [31:0] instr);
    return (instr[6:0] == OPC_OP) && (instr[31:25] == FUNCT7_MULDIV) && instr[14];
  endfunction

endpackage

// File: rtl/id_control_sequencer_imm_select_decoder.sv
// rtl/id_control_sequencer_imm_select_decoder.sv - combinational opcode to immediate-type / illegal decode
module imm_select_decoder
  import id_control_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_select_o,
  output logic       illegal_o
);

  always_comb begin
    imm_select_o = IMM_NONE;
    illegal_o    = 1'b0;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: imm_select_o = IMM_I;
      OPC_STORE:            imm_select_o = IMM_S;
      OPC_LUI, OPC_AUIPC:   imm_select_o = IMM_U;
      OPC_BRANCH:           imm_select_o = IMM_B;
      OPC_JAL:              imm_select_o = IMM_J;
      OPC_OP:               imm_select_o = IMM_NONE;
      default:              illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_control_sequencer.sv
// rtl/id_control_sequencer.sv - decode-stage handshake register with divide hold sequencer
module id_control_sequencer
  import id_control_sequencer_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        FLUSH,
  input  logic        EX_READY,
  output logic [2:0]  IMM_SELECT,
  output logic        OUT_VALID,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [2:0]  OUT_IMM_SELECT,
  output logic        OUT_ILLEGAL,
  output logic        MDU_BUSY
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [2:0]       out_sel_q, out_sel_d;
  logic             out_ill_q, out_ill_d;
  logic             illegal;
  logic             xfer_in, xfer_out;

  imm_select_decoder u_dec (
    .opcode_i     (INSTRUCTION[6:0]),
    .imm_select_o (IMM_SELECT),
    .illegal_o    (illegal)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_sel_d   = out_sel_q;
    out_ill_d   = out_ill_q;

    IN_READY = (state_q == ST_RUN) && !FLUSH && (!out_valid_q || EX_READY);
    xfer_in  = IN_VALID && IN_READY;
    xfer_out = out_valid_q && EX_READY;

    if (FLUSH) begin
      // Kill the payload and any pending divide hold; payload bits are left as-is.
      state_d     = ST_RUN;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (xfer_in) begin
        out_valid_d = 1'b1;
        out_instr_d = INSTRUCTION;
        out_sel_d   = IMM_SELECT;
        out_ill_d   = illegal;
      end else if (xfer_out) begin
        out_valid_d = 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (xfer_in && is_divide(INSTRUCTION)) begin
            state_d = ST_MDU_HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_MDU_HOLD: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_sel_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_sel_q   <= out_sel_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign OUT_VALID       = out_valid_q;
  assign OUT_INSTRUCTION = out_instr_q;
  assign OUT_IMM_SELECT  = out_sel_q;
  assign OUT_ILLEGAL     = out_ill_q;
  assign MDU_BUSY        = (state_q == ST_MDU_HOLD);

endmodule
